// File: rtl/riscv_hwloop_cfg_sequencer_pkg.sv
// Shared types for the hardware-loop configuration sequencer.
package riscv_hwloop_pkg;

    localparam int unsigned HWLP_DATA_W = 32;

    typedef enum logic [2:0] {
        HWLP_OP_START = 3'b000,
        HWLP_OP_END   = 3'b001,
        HWLP_OP_COUNT = 3'b010,
        HWLP_OP_SETUP = 3'b011,
        HWLP_OP_CLEAR = 3'b100
    } hwlp_op_e;

    typedef enum logic {
        HWLP_CFG_IDLE,
        HWLP_CFG_DRAIN
    } hwlp_cfg_state_e;

    // One configuration request payload (loop index carried separately,
    // since its width depends on the number of loops).
    typedef struct packed {
        hwlp_op_e               op;
        logic [HWLP_DATA_W-1:0] start_addr;
        logic [HWLP_DATA_W-1:0] end_addr;
        logic [HWLP_DATA_W-1:0] count;
    } hwlp_cfg_t;

endpackage

// File: rtl/riscv_hwloop_cfg_sequencer_if.sv
// Configuration request channel from the ID-stage decoder to the sequencer.
interface riscv_hwloop_cfg_sequencer_if
    import riscv_hwloop_pkg::*;
#(
    parameter int unsigned N_REGS = 2
);
    localparam int unsigned N_REG_BITS = $clog2(N_REGS);

    logic                   cfg_valid_i;
    logic                   cfg_ready_o;
    logic [2:0]             cfg_op_i;
    logic [N_REG_BITS-1:0]  cfg_regid_i;
    logic [HWLP_DATA_W-1:0] cfg_start_i;
    logic [HWLP_DATA_W-1:0] cfg_end_i;
    logic [HWLP_DATA_W-1:0] cfg_count_i;

    // Requester side (ID-stage decoder).
    modport master (
        output cfg_valid_i,
        output cfg_op_i,
        output cfg_regid_i,
        output cfg_start_i,
        output cfg_end_i,
        output cfg_count_i,
        input  cfg_ready_o
    );

    // Sequencer side.
    modport slave (
        input  cfg_valid_i,
        input  cfg_op_i,
        input  cfg_regid_i,
        input  cfg_start_i,
        input  cfg_end_i,
        input  cfg_count_i,
        output cfg_ready_o
    );

endinterface

// File: rtl/riscv_hwloop_cfg_sequencer_reg_slice.sv
// One hardware loop's register set: start, end, counter and in-flight flag.
module riscv_hwloop_reg_slice
    import riscv_hwloop_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  hwlp_cfg_t              wdata,
    input  logic                   dec,
    input  logic                   clr_flag,
    output logic [HWLP_DATA_W-1:0] start_addr,
    output logic [HWLP_DATA_W-1:0] end_addr,
    output logic [HWLP_DATA_W-1:0] counter,
    output logic                   dec_in_flight
);

    logic wr_start;
    logic wr_end;
    logic wr_count;
    logic wr_clear;
    logic wr_flag_clr;

    // Decode which fields a commit touches; reserved ops touch nothing.
    always_comb begin
        wr_start    = 1'b0;
        wr_end      = 1'b0;
        wr_count    = 1'b0;
        wr_clear    = 1'b0;
        wr_flag_clr = 1'b0;
        if (we) begin
            case (wdata.op)
                HWLP_OP_START: wr_start = 1'b1;
                HWLP_OP_END:   wr_end   = 1'b1;
                HWLP_OP_COUNT: wr_count = 1'b1;
                HWLP_OP_SETUP: begin
                    wr_start    = 1'b1;
                    wr_end      = 1'b1;
                    wr_count    = 1'b1;
                    wr_flag_clr = 1'b1;
                end
                HWLP_OP_CLEAR: begin
                    wr_clear    = 1'b1;
                    wr_flag_clr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Address registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_addr <= '0;
            end_addr   <= '0;
        end else begin
            if (wr_start) start_addr <= wdata.start_addr;
            if (wr_end)   end_addr   <= wdata.end_addr;
        end
    end

    // Iteration counter: commit has priority, decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter <= '0;
        end else if (wr_count) begin
            counter <= wdata.count;
        end else if (wr_clear) begin
            counter <= '0;
        end else if (dec && (counter != '0)) begin
            counter <= counter - HWLP_DATA_W'(1);
        end
    end

    // In-flight flag: a new decrement beats any clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_in_flight <= 1'b0;
        end else if (dec) begin
            dec_in_flight <= 1'b1;
        end else if (wr_flag_clr || clr_flag) begin
            dec_in_flight <= 1'b0;
        end
    end

endmodule

// File: rtl/riscv_hwloop_cfg_sequencer.sv
// Hardware-loop register owner: orders ID-stage config writes against
// controller decrements so a write never races an in-flight decrement.
module riscv_hwloop_cfg_sequencer
    import riscv_hwloop_pkg::*;
#(
    parameter int unsigned N_REGS = 2
)(
    input  logic                                  clk,
    input  logic                                  rst_n,
    riscv_hwloop_cfg_sequencer_if.slave           cfg,
    input  logic [N_REGS-1:0]                     hwlp_dec_cnt_i,
    input  logic                                  id_valid_i,
    input  logic                                  ex_valid_i,
    input  logic                                  flush_i,
    output logic [N_REGS-1:0][HWLP_DATA_W-1:0]    hwlp_start_addr_o,
    output logic [N_REGS-1:0][HWLP_DATA_W-1:0]    hwlp_end_addr_o,
    output logic [N_REGS-1:0][HWLP_DATA_W-1:0]    hwlp_counter_o,
    output logic [N_REGS-1:0]                     hwlp_dec_cnt_id_o,
    output logic [N_REGS-1:0]                     hwlp_active_o
);

    localparam int unsigned N_REG_BITS = $clog2(N_REGS);

    hwlp_cfg_state_e        state_q, state_d;
    logic [N_REG_BITS-1:0]  lat_regid_q, lat_regid_d;
    hwlp_cfg_t              lat_req_q, lat_req_d;

    logic [N_REGS-1:0]      dec;
    logic [N_REGS-1:0]      conflict_vec;
    hwlp_cfg_t              live_req;
    hwlp_cfg_t              commit_req;
    logic [N_REG_BITS-1:0]  commit_regid;
    logic                   commit_en;
    logic                   ready_c;

    // Qualified decrements and per-loop write-conflict view.
    assign dec          = hwlp_dec_cnt_i & {N_REGS{id_valid_i}};
    assign conflict_vec = hwlp_dec_cnt_id_o | dec;

    // Pack the live request from the channel.
    always_comb begin
        live_req            = '0;
        live_req.op         = hwlp_op_e'(cfg.cfg_op_i);
        live_req.start_addr = cfg.cfg_start_i;
        live_req.end_addr   = cfg.cfg_end_i;
        live_req.count      = cfg.cfg_count_i;
    end

    // FSM state and parked request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= HWLP_CFG_IDLE;
            lat_regid_q <= '0;
            lat_req_q   <= '0;
        end else begin
            state_q     <= state_d;
            lat_regid_q <= lat_regid_d;
            lat_req_q   <= lat_req_d;
        end
    end

    // Next state, handshake and commit selection.
    always_comb begin
        state_d      = state_q;
        lat_regid_d  = lat_regid_q;
        lat_req_d    = lat_req_q;
        ready_c      = 1'b0;
        commit_en    = 1'b0;
        commit_regid = cfg.cfg_regid_i;
        commit_req   = live_req;
        case (state_q)
            HWLP_CFG_IDLE: begin
                if (cfg.cfg_valid_i) begin
                    if (!conflict_vec[cfg.cfg_regid_i]) begin
                        ready_c   = 1'b1;
                        commit_en = 1'b1;
                    end else begin
                        lat_regid_d = cfg.cfg_regid_i;
                        lat_req_d   = live_req;
                        state_d     = HWLP_CFG_DRAIN;
                    end
                end
            end
            HWLP_CFG_DRAIN: begin
                commit_regid = lat_regid_q;
                commit_req   = lat_req_q;
                if (!conflict_vec[lat_regid_q]) begin
                    commit_en = 1'b1;
                    state_d   = HWLP_CFG_IDLE;
                end
            end
            default: state_d = HWLP_CFG_IDLE;
        endcase
    end

    assign cfg.cfg_ready_o = ready_c & rst_n;

    // One register slice per hardware loop.
    for (genvar i = 0; i < N_REGS; i++) begin : g_loop
        logic slice_we;

        assign slice_we = commit_en && (commit_regid == N_REG_BITS'(i));

        riscv_hwloop_reg_slice u_slice (
            .clk           (clk),
            .rst_n         (rst_n),
            .we            (slice_we),
            .wdata         (commit_req),
            .dec           (dec[i]),
            .clr_flag      (ex_valid_i | flush_i),
            .start_addr    (hwlp_start_addr_o[i]),
            .end_addr      (hwlp_end_addr_o[i]),
            .counter       (hwlp_counter_o[i]),
            .dec_in_flight (hwlp_dec_cnt_id_o[i])
        );

        assign hwlp_active_o[i] = (hwlp_counter_o[i] != '0);
    end

endmodule

// File: tb/tb_riscv_hwloop_cfg_sequencer.sv
// Directed bench for the hardware-loop configuration sequencer.
module tb_riscv_hwloop_cfg_sequencer;
    import riscv_hwloop_pkg::*;

    localparam int unsigned N_REGS = 2;

    logic                              clk;
    logic                              rst_n;
    logic [N_REGS-1:0]                 hwlp_dec_cnt;
    logic                              id_valid;
    logic                              ex_valid;
    logic                              flush;
    logic [N_REGS-1:0][HWLP_DATA_W-1:0] start_addr;
    logic [N_REGS-1:0][HWLP_DATA_W-1:0] end_addr;
    logic [N_REGS-1:0][HWLP_DATA_W-1:0] counter;
    logic [N_REGS-1:0]                 dec_cnt_id;
    logic [N_REGS-1:0]                 active;

    int n_checks = 0;
    int n_errors = 0;

    riscv_hwloop_cfg_sequencer_if #(.N_REGS(N_REGS)) cfg_if ();

    riscv_hwloop_cfg_sequencer #(.N_REGS(N_REGS)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cfg               (cfg_if.slave),
        .hwlp_dec_cnt_i    (hwlp_dec_cnt),
        .id_valid_i        (id_valid),
        .ex_valid_i        (ex_valid),
        .flush_i           (flush),
        .hwlp_start_addr_o (start_addr),
        .hwlp_end_addr_o   (end_addr),
        .hwlp_counter_o    (counter),
        .hwlp_dec_cnt_id_o (dec_cnt_id),
        .hwlp_active_o     (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cfg(input logic [2:0] op, input logic regid,
                             input logic [31:0] s, input logic [31:0] e, input logic [31:0] c);
        cfg_if.cfg_valid_i = 1'b1;
        cfg_if.cfg_op_i    = op;
        cfg_if.cfg_regid_i = regid;
        cfg_if.cfg_start_i = s;
        cfg_if.cfg_end_i   = e;
        cfg_if.cfg_count_i = c;
        #1;
    endtask

    task automatic idle_cfg();
        cfg_if.cfg_valid_i = 1'b0;
        cfg_if.cfg_op_i    = 3'b000;
        cfg_if.cfg_regid_i = 1'b0;
        cfg_if.cfg_start_i = '0;
        cfg_if.cfg_end_i   = '0;
        cfg_if.cfg_count_i = '0;
    endtask

    // Single-cycle controller decrement of the loops in mask.
    task automatic pulse_dec(input logic [1:0] mask);
        hwlp_dec_cnt = mask;
        id_valid     = 1'b1;
        step();
        hwlp_dec_cnt = '0;
        id_valid     = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        hwlp_dec_cnt = '0;
        id_valid     = 1'b0;
        ex_valid     = 1'b0;
        flush        = 1'b0;
        idle_cfg();

        // Reset: everything zero, ready held low even with a request pending.
        step();
        drive_cfg(3'b011, 1'b0, 32'h55, 32'h66, 32'h7);
        check("rst_ready", 32'(cfg_if.cfg_ready_o), 32'h0);
        step();
        check("rst_cnt0", counter[0], 32'h0);
        check("rst_cnt1", counter[1], 32'h0);
        check("rst_start0", start_addr[0], 32'h0);
        check("rst_end1", end_addr[1], 32'h0);
        check("rst_flags", 32'(dec_cnt_id), 32'h0);
        check("rst_active", 32'(active), 32'h0);
        idle_cfg();
        rst_n = 1'b1;
        step();
        check("post_rst_cnt0", counter[0], 32'h0);

        // SETUP loop 0: accepted same cycle, visible after the edge.
        drive_cfg(3'b011, 1'b0, 32'h100, 32'h120, 32'd3);
        check("setup_ready", 32'(cfg_if.cfg_ready_o), 32'h1);
        step();
        idle_cfg();
        check("setup_start0", start_addr[0], 32'h100);
        check("setup_end0", end_addr[0], 32'h120);
        check("setup_cnt0", counter[0], 32'd3);
        check("setup_active", 32'(active), 32'h1);

        // COUNT loop 1 = 2, decrement it, then retire.
        drive_cfg(3'b010, 1'b1, 32'h0, 32'h0, 32'd2);
        check("cnt1_ready", 32'(cfg_if.cfg_ready_o), 32'h1);
        step();
        idle_cfg();
        check("cnt1_val", counter[1], 32'd2);
        check("cnt1_start_kept", start_addr[1], 32'h0);
        pulse_dec(2'b10);
        check("dec1_cnt", counter[1], 32'd1);
        check("dec1_flag", 32'(dec_cnt_id), 32'h2);
        ex_valid = 1'b1;
        step();
        ex_valid = 1'b0;
        check("ex_clr_flag", 32'(dec_cnt_id), 32'h0);
        check("ex_cnt1_kept", counter[1], 32'd1);

        // Decrement loop 0, then COUNT=5 to loop 0 must drain behind it.
        pulse_dec(2'b01);
        check("drain_dec_cnt0", counter[0], 32'd2);
        drive_cfg(3'b010, 1'b0, 32'h0, 32'h0, 32'd5);
        check("drain_busy_ready", 32'(cfg_if.cfg_ready_o), 32'h0);
        step();
        check("drain_wait_ready", 32'(cfg_if.cfg_ready_o), 32'h0);
        check("drain_wait_cnt0", counter[0], 32'd2);
        step();
        ex_valid = 1'b1;
        #1;
        check("drain_ex_ready", 32'(cfg_if.cfg_ready_o), 32'h0);
        step();
        ex_valid = 1'b0;
        check("drain_free_flag", 32'(dec_cnt_id), 32'h0);
        check("drain_free_ready", 32'(cfg_if.cfg_ready_o), 32'h0);
        check("drain_free_cnt0", counter[0], 32'd2);
        step();
        check("drain_commit_cnt0", counter[0], 32'd5);
        check("drain_idle_ready", 32'(cfg_if.cfg_ready_o), 32'h1);
        step();
        idle_cfg();
        check("drain_final_cnt0", counter[0], 32'd5);

        // CLEAR loop 0, then decrement at zero saturates but still flags.
        drive_cfg(3'b100, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        idle_cfg();
        check("clear_cnt0", counter[0], 32'h0);
        check("clear_active", 32'(active), 32'h2);
        check("clear_start_kept", start_addr[0], 32'h100);
        pulse_dec(2'b01);
        check("sat_cnt0", counter[0], 32'h0);
        check("sat_active0", 32'(active[0]), 32'h0);
        check("sat_flag", 32'(dec_cnt_id), 32'h1);
        ex_valid = 1'b1;
        step();
        ex_valid = 1'b0;

        // COUNT loop 0 = 4, then COUNT loop 1 = 7 alongside a loop-0 decrement.
        drive_cfg(3'b010, 1'b0, 32'h0, 32'h0, 32'd4);
        step();
        idle_cfg();
        drive_cfg(3'b010, 1'b1, 32'h0, 32'h0, 32'd7);
        hwlp_dec_cnt = 2'b01;
        id_valid     = 1'b1;
        #1;
        check("par_ready", 32'(cfg_if.cfg_ready_o), 32'h1);
        step();
        hwlp_dec_cnt = '0;
        id_valid     = 1'b0;
        idle_cfg();
        check("par_cnt1", counter[1], 32'd7);
        check("par_cnt0", counter[0], 32'd3);
        check("par_flag", 32'(dec_cnt_id), 32'h1);

        // Flush clears the flag and leaves the counter alone.
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_flag", 32'(dec_cnt_id), 32'h0);
        check("flush_cnt0", counter[0], 32'd3);

        // Set beats clear in the same cycle.
        hwlp_dec_cnt = 2'b10;
        id_valid     = 1'b1;
        ex_valid     = 1'b1;
        step();
        hwlp_dec_cnt = '0;
        id_valid     = 1'b0;
        ex_valid     = 1'b0;
        check("setwins_flag", 32'(dec_cnt_id), 32'h2);
        check("setwins_cnt1", counter[1], 32'd6);
        ex_valid = 1'b1;
        step();
        ex_valid = 1'b0;

        // START / END single writes and a reserved op.
        drive_cfg(3'b000, 1'b1, 32'h200, 32'hdead, 32'd99);
        step();
        drive_cfg(3'b001, 1'b1, 32'hbeef, 32'h240, 32'd99);
        step();
        drive_cfg(3'b111, 1'b0, 32'h999, 32'h999, 32'd99);
        check("rsvd_ready", 32'(cfg_if.cfg_ready_o), 32'h1);
        step();
        idle_cfg();
        check("start1", start_addr[1], 32'h200);
        check("end1", end_addr[1], 32'h240);
        check("start_end_cnt1", counter[1], 32'd6);
        check("rsvd_cnt0", counter[0], 32'd3);
        check("rsvd_start0", start_addr[0], 32'h100);
        check("rsvd_end0", end_addr[0], 32'h120);

        // Reset while draining abandons the parked write.
        pulse_dec(2'b10);
        drive_cfg(3'b010, 1'b1, 32'h0, 32'h0, 32'd9);
        check("rd_busy_ready", 32'(cfg_if.cfg_ready_o), 32'h0);
        step();
        idle_cfg();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rd_cnt0", counter[0], 32'h0);
        check("rd_cnt1", counter[1], 32'h0);
        check("rd_start0", start_addr[0], 32'h0);
        check("rd_flags", 32'(dec_cnt_id), 32'h0);
        step();
        step();
        check("rd_no_commit", counter[1], 32'h0);
        drive_cfg(3'b011, 1'b1, 32'h10, 32'h20, 32'd1);
        check("rd_idle_ready", 32'(cfg_if.cfg_ready_o), 32'h1);
        step();
        idle_cfg();
        check("rd_setup_cnt1", counter[1], 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
